multi_approach_signal_ctrl: RTL and testbench
=============================================

# multi_approach_signal_ctrl

Parametrised intersection signal controller for N approaches, the next-generation replacement for the fixed four-way controller. It serves approaches round-robin with per-approach demand sensing, programmable green/yellow/all-red phase lengths, per-approach emergency preemption and a global alert hold. All outputs are registered. It sits between the sensor/alert input conditioning and the lamp drivers.

## Interface
- N_APPR, 4: number of approaches, 2..16.
- T_GREEN, 20: green phase length in cycles, ≥1.
- T_YELLOW, 4: yellow phase length in cycles, ≥1.
- T_ALLRED, 1: all-red clearance length in cycles, ≥1.
- CNT_W, 5: phase counter width. Must satisfy 2^CNT_W > max(T_GREEN, T_YELLOW, T_ALLRED).
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- sensor  in  N_APPR  demand per approach. Bit i = 1 means vehicle waiting.
- emrg_req  in  N_APPR  emergency preemption request per approach. Level-sensitive.
- alert1  in  1  ambulance alert. Level-sensitive.
- alert2  in  1  police alert. Level-sensitive.
- light  out  3*N_APPR  lamp state. Approach i uses bits [3i+2:3i], encoded {R,Y,G}: 100 red, 010 yellow, 001 green. No other codes are legal.
- active_idx  out  4  approach currently owning or last owning right-of-way.
- count  out  CNT_W  remaining cycles in the current timed phase.
- emrg_active  out  1  high while in PREEMPT.
- ambulance  out  1  registered copy of alert1.
- police  out  1  registered copy of alert2.

## Operation
- States: ALLRED, GREEN, YELLOW, PREEMPT, HOLD.
- Priority order: reset > alert hold > emergency > normal cycling.
- Reset (rst=0 at an edge) sets the following values:
  - State ALLRED.
  - All lights 100.
  - count 0.
  - active_idx N_APPR-1, so the first pick starts at 0.
  - emrg_active, ambulance and police all 0.
- Phase counter: loads T-1 on entry to a timed state and decrements each cycle. Exit happens on the cycle count==0, so a phase lasts exactly T cycles. count never wraps.
- ALLRED at count==0 picks the next approach:
  - Search round-robin from active_idx+1 (mod N_APPR), wrapping, including active_idx last. Take the first index with sensor=1.
  - Found: GREEN for that approach, active_idx updated.
  - None found: remain in ALLRED with count held at 0. Re-evaluate every cycle.
- GREEN at count==0 goes to YELLOW. Sensor changes during GREEN do not shorten or extend it.
- YELLOW at count==0 goes to ALLRED.
- Emergency handling. Lowest-index asserted emrg_req bit wins (index e). It is evaluated every cycle outside HOLD and PREEMPT.
  - In GREEN with active_idx==e: go directly to PREEMPT. The light stays green with no glitch.
  - In GREEN with active_idx≠e: go to YELLOW immediately, reloading count to T_YELLOW-1, then ALLRED.
  - In YELLOW: finish yellow normally.
  - In ALLRED: at count==0, select e instead of the round-robin pick and enter PREEMPT, not GREEN. active_idx becomes e.
- PREEMPT:
  - Approach e is green, all others red.
  - count holds 0. emrg_active is 1.
  - The state persists while emrg_req[e]=1. Other emrg_req bits are ignored.
  - When emrg_req[e] drops: go to YELLOW for e, then ALLRED. Round-robin resumes from e+1.
- HOLD:
  - Entry: any state with alert1|alert2 =1 goes to HOLD on the next edge.
  - All lights are 100, count 0, emrg_active 0.
  - Exit: when both alerts are 0, go to ALLRED with count loaded T_ALLRED-1. active_idx is unchanged.
  - A green interrupted by alert gets no yellow. Alert hold is an immediate all-red by design.
- Exactly one approach is ever non-red. No state drives two approaches non-red.

## Timing
- All outputs are registered.
- An input sampled at edge k affects outputs after edge k. Single-cycle latency applies to alert entry, preempt entry from matching GREEN, and forced yellow.
- ambulance and police lag alert1 and alert2 by exactly 1 cycle.
- Normal cycle length with full demand is N_APPR×(T_GREEN+T_YELLOW+T_ALLRED) cycles. Defaults with 4 approaches give 100 cycles.
- Simultaneous events:
  - Alert and emrg_req in the same cycle: HOLD wins. The emergency is serviced after HOLD exits, through ALLRED.
  - emrg_req and a green expiry in the same cycle: the forced YELLOW and the normal YELLOW are identical.
- Reset asserted mid-phase overrides everything in that cycle.
- Reset has no effect on ambulance or police beyond clearing them. Alerts still sampled high re-assert them 1 cycle after reset releases.

## Test plan
- Defaults, all sensors 1 after reset release: approach 0 green for cycles 2..21, yellow for 22..25, all-red for 26, approach 1 green at 27. The full sequence repeats every 100 cycles.
- Sensors set to 0101: only approaches 0 and 2 get green, alternating. With all sensors 0, the block parks in ALLRED with count=0 and all lights 100.
- With approach 1 green, pulse emrg_req[3] high for 30 cycles: approach 1 goes yellow next cycle, 4 cycles yellow, 1 all-red, then approach 3 green with emrg_active=1. After the drop, 4 yellow and 1 all-red, then approach 0 green.
- With approach 2 green, raise emrg_req[2] together with emrg_req[3]: PREEMPT on approach 2 with no light change. Approach 3 is served only after approach 2 releases.
- Raise alert1 for 50 cycles during GREEN: all lights 100 the next cycle, ambulance=1 one cycle after alert1. After the drop, 1 all-red cycle, then the next approach after active_idx goes green. Repeat with alert2 plus emrg_req together: HOLD first.
- With N_APPR=8 and T_GREEN=10, pull rst low mid-green for 1 cycle: all outputs return to their reset values and approach 0 is served next.

Source files
------------

// File: rtl/multi_approach_signal_ctrl.sv
// Round-robin signal controller for N approaches with demand sensing,
// per-approach emergency preemption and a global alert hold. All outputs registered.
//
// state   | meaning
// ALLRED  | clearance interval; at count==0 picks the next approach (or parks)
// GREEN   | active approach green for T_GREEN cycles
// YELLOW  | active approach yellow for T_YELLOW cycles
// PREEMPT | emergency approach held green while its request stays high
// HOLD    | alert hold, every lamp red until both alerts drop
module multi_approach_signal_ctrl #(
    parameter int N_APPR   = 4,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 1,
    parameter int CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_APPR-1:0]     sensor,
    input  logic [N_APPR-1:0]     emrg_req,
    input  logic                  alert1,
    input  logic                  alert2,
    output logic [3*N_APPR-1:0]   light,
    output logic [3:0]            active_idx,
    output logic [CNT_W-1:0]      count,
    output logic                  emrg_active,
    output logic                  ambulance,
    output logic                  police
);

    typedef enum logic [2:0] {
        S_ALLRED,
        S_GREEN,
        S_YELLOW,
        S_PREEMPT,
        S_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] C_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] C_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] C_ALLRED = CNT_W'(T_ALLRED - 1);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     count_nx;
    logic [3:0]           idx_nx;
    logic [3*N_APPR-1:0]  light_nx;

    logic                 emrg_any;
    logic [3:0]           emrg_idx;
    logic                 emrg_cur;
    logic                 hi_found, lo_found, rr_found;
    logic [3:0]           hi_idx, lo_idx, rr_idx;

    // Lowest asserted request wins; emrg_cur tracks the request of the owning approach.
    always_comb begin
        emrg_any = 1'b0;
        emrg_idx = '0;
        emrg_cur = 1'b0;
        for (int i = N_APPR - 1; i >= 0; i--) begin
            if (emrg_req[i]) begin
                emrg_any = 1'b1;
                emrg_idx = 4'(i);
            end
            if (4'(i) == active_idx) emrg_cur = emrg_req[i];
        end
    end

    // Round-robin: lowest demanding index above active_idx, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_APPR - 1; i >= 0; i--) begin
            if (sensor[i]) begin
                if (4'(i) > active_idx) begin
                    hi_found = 1'b1;
                    hi_idx   = 4'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = 4'(i);
                end
            end
        end
        rr_found = hi_found | lo_found;
        rr_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        idx_nx   = active_idx;
        if (alert1 || alert2) begin
            state_nx = S_HOLD;
            count_nx = '0;
        end else begin
            case (state)
                S_HOLD: begin
                    state_nx = S_ALLRED;
                    count_nx = C_ALLRED;
                end
                S_ALLRED: begin
                    if (count != '0) begin
                        count_nx = count - 1'b1;
                    end else if (emrg_any) begin
                        state_nx = S_PREEMPT;
                        idx_nx   = emrg_idx;
                        count_nx = '0;
                    end else if (rr_found) begin
                        state_nx = S_GREEN;
                        idx_nx   = rr_idx;
                        count_nx = C_GREEN;
                    end
                end
                S_GREEN: begin
                    if (emrg_any && emrg_idx == active_idx) begin
                        state_nx = S_PREEMPT;
                        count_nx = '0;
                    end else if (emrg_any || count == '0) begin
                        state_nx = S_YELLOW;
                        count_nx = C_YELLOW;
                    end else begin
                        count_nx = count - 1'b1;
                    end
                end
                S_YELLOW: begin
                    if (count == '0) begin
                        state_nx = S_ALLRED;
                        count_nx = C_ALLRED;
                    end else begin
                        count_nx = count - 1'b1;
                    end
                end
                S_PREEMPT: begin
                    if (!emrg_cur) begin
                        state_nx = S_YELLOW;
                        count_nx = C_YELLOW;
                    end
                end
                default: begin
                    state_nx = S_ALLRED;
                    count_nx = '0;
                end
            endcase
        end
    end

    // Lamps decoded from the next state so the registered output lines up with it.
    always_comb begin
        light_nx = {N_APPR{3'b100}};
        for (int i = 0; i < N_APPR; i++) begin
            if (4'(i) == idx_nx) begin
                if (state_nx == S_GREEN || state_nx == S_PREEMPT)
                    light_nx[3*i +: 3] = 3'b001;
                else if (state_nx == S_YELLOW)
                    light_nx[3*i +: 3] = 3'b010;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_ALLRED;
            count       <= '0;
            active_idx  <= 4'(N_APPR - 1);
            light       <= {N_APPR{3'b100}};
            emrg_active <= 1'b0;
            ambulance   <= 1'b0;
            police      <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            active_idx  <= idx_nx;
            light       <= light_nx;
            emrg_active <= (state_nx == S_PREEMPT);
            ambulance   <= alert1;
            police      <= alert2;
        end
    end

endmodule

// File: tb/tb_multi_approach_signal_ctrl.sv
// Randomized bench for multi_approach_signal_ctrl against a phase-level
// reference model, plus directed checks at the key timing points.
module tb_multi_approach_signal_ctrl;
    localparam int N  = 4;
    localparam int TG = 20;
    localparam int TY = 4;
    localparam int TA = 1;
    localparam int CW = 5;

    localparam int PH_RED   = 0;
    localparam int PH_GO    = 1;
    localparam int PH_AMBER = 2;
    localparam int PH_PRE   = 3;
    localparam int PH_HOLD  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    sensor;
    logic [N-1:0]    emrg_req;
    logic            alert1;
    logic            alert2;
    logic [3*N-1:0]  light;
    logic [3:0]      active_idx;
    logic [CW-1:0]   count;
    logic            emrg_active;
    logic            ambulance;
    logic            police;

    always #5 clk = ~clk;

    multi_approach_signal_ctrl #(
        .N_APPR(N), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .emrg_req(emrg_req),
        .alert1(alert1), .alert2(alert2), .light(light), .active_idx(active_idx),
        .count(count), .emrg_active(emrg_active), .ambulance(ambulance), .police(police)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int m_ph  = PH_RED;
    int m_cnt = 0;
    int m_idx = N - 1;
    bit m_amb = 1'b0;
    bit m_pol = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock of the rules: reset, then alert hold, then emergency, then cycling.
    task automatic model_step();
        int e;
        logic [N-1:0] rot;
        e = -1;
        for (int i = N - 1; i >= 0; i--) if (emrg_req[i]) e = i;
        if (!rst) begin
            m_ph = PH_RED; m_cnt = 0; m_idx = N - 1; m_amb = 0; m_pol = 0;
        end else begin
            m_amb = alert1;
            m_pol = alert2;
            if (alert1 || alert2) begin
                m_ph = PH_HOLD; m_cnt = 0;
            end else if (m_ph == PH_HOLD) begin
                m_ph = PH_RED; m_cnt = TA - 1;
            end else if (m_ph == PH_RED) begin
                if (m_cnt > 0) m_cnt--;
                else if (e >= 0) begin
                    m_ph = PH_PRE; m_idx = e; m_cnt = 0;
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        rot = sensor >> ((m_idx + k) % N);
                        if (rot[0]) begin
                            m_ph = PH_GO; m_idx = (m_idx + k) % N; m_cnt = TG - 1;
                            break;
                        end
                    end
                end
            end else if (m_ph == PH_GO) begin
                if (e == m_idx) begin
                    m_ph = PH_PRE; m_cnt = 0;
                end else if (e >= 0 || m_cnt == 0) begin
                    m_ph = PH_AMBER; m_cnt = TY - 1;
                end else m_cnt--;
            end else if (m_ph == PH_AMBER) begin
                if (m_cnt == 0) begin
                    m_ph = PH_RED; m_cnt = TA - 1;
                end else m_cnt--;
            end else if (m_ph == PH_PRE) begin
                rot = emrg_req >> m_idx;
                if (!rot[0]) begin
                    m_ph = PH_AMBER; m_cnt = TY - 1;
                end
            end
        end
    endtask

    function automatic logic [3*N-1:0] exp_light();
        logic [3*N-1:0] v;
        logic [2:0]     c;
        v = '0;
        for (int i = 0; i < N; i++) begin
            c = 3'b100;
            if (i == m_idx && (m_ph == PH_GO || m_ph == PH_PRE)) c = 3'b001;
            else if (i == m_idx && m_ph == PH_AMBER) c = 3'b010;
            v[3*i +: 3] = c;
        end
        return v;
    endfunction

    task automatic step();
        int nonred;
        @(posedge clk);
        model_step();
        #1;
        chk("light", light, exp_light());
        chk("active_idx", active_idx, m_idx);
        chk("count", count, m_cnt);
        chk("emrg_active", emrg_active, m_ph == PH_PRE);
        chk("ambulance", ambulance, m_amb);
        chk("police", police, m_pol);
        nonred = 0;
        for (int i = 0; i < N; i++) if (light[3*i +: 3] != 3'b100) nonred++;
        chk("one_non_red", nonred <= 1, 1);
    endtask

    task automatic wait_green(input int idx);
        int b;
        b = 0;
        while (!(m_ph == PH_GO && m_idx == idx) && b < 400) begin
            step();
            b++;
        end
        chk("wait_green_lamp", light[3*idx +: 3], 3'b001);
    endtask

    initial begin
        rst = 1'b0; sensor = '0; emrg_req = '0; alert1 = 1'b0; alert2 = 1'b0;
        step();
        chk("rst_light", light, 12'h924);
        chk("rst_idx", active_idx, 4'd3);
        chk("rst_count", count, 0);
        chk("rst_emrg", emrg_active, 0);

        rst = 1'b1; sensor = 4'hF;
        for (int k = 1; k <= 101; k++) begin
            step();
            if (k == 1)   chk("first_green", light, 12'h921);
            if (k == 1)   chk("first_green_cnt", count, 19);
            if (k == 20)  chk("green_last_cnt", count, 0);
            if (k == 21)  chk("yellow_start", light, 12'h922);
            if (k == 21)  chk("yellow_cnt", count, 3);
            if (k == 25)  chk("allred", light, 12'h924);
            if (k == 26)  chk("appr1_green", light, 12'h90C);
            if (k == 101) chk("period_100", light, 12'h921);
        end

        sensor = 4'b0101;
        repeat (120) step();
        sensor = 4'b0000;
        repeat (40) step();
        chk("park_light", light, 12'h924);
        chk("park_count", count, 0);

        sensor = 4'hF;
        wait_green(1);
        emrg_req = 4'b1000;
        for (int s = 1; s <= 30; s++) begin
            step();
            if (s == 1) chk("forced_yellow", light, 12'h914);
            if (s == 6) chk("preempt_lamp", light, 12'h324);
            if (s == 6) chk("preempt_flag", emrg_active, 1);
        end
        emrg_req = '0;
        repeat (40) step();

        wait_green(2);
        emrg_req = 4'b1100;
        step();
        chk("preempt_same_lamp", light, 12'h864);
        chk("preempt_same_flag", emrg_active, 1);
        repeat (20) step();
        emrg_req = 4'b1000;
        repeat (20) step();
        emrg_req = '0;
        repeat (30) step();

        wait_green(0);
        alert1 = 1'b1;
        step();
        chk("hold_lamp", light, 12'h924);
        chk("hold_amb", ambulance, 1);
        repeat (49) step();
        alert1 = 1'b0;
        repeat (30) step();

        alert2 = 1'b1; emrg_req = 4'b0010;
        repeat (20) step();
        chk("hold_over_emrg", emrg_active, 0);
        alert2 = 1'b0;
        repeat (30) step();
        emrg_req = '0;
        repeat (30) step();

        wait_green(2);
        repeat (5) step();
        rst = 1'b0;
        step();
        chk("midrst_light", light, 12'h924);
        chk("midrst_idx", active_idx, 4'd3);
        rst = 1'b1;
        step();
        chk("midrst_first", light, 12'h921);

        for (int c = 0; c < 4000; c++) begin
            sensor = ($urandom_range(3) == 0) ? N'($urandom & $urandom) : N'($urandom);
            if ($urandom_range(24) == 0)
                emrg_req = ($urandom_range(2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(199) == 0) alert1 = ~alert1;
            if ($urandom_range(249) == 0) alert2 = ~alert2;
            rst = ($urandom_range(499) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
